// File: rtl/ucsbece154b_perf_monitor.sv
// Branch/jump prediction performance monitor: delays fetch-stage predictions to E, flags mispredictions, and keeps eight counters.
// Define PERF_SATURATE_EN to make counters saturate at all-ones instead of wrapping.
module ucsbece154b_perf_monitor #(
  parameter int CNT_WIDTH = 32,
  parameter int PRED_LAT  = 2,
  parameter int PC_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable_i,
  input  logic                 clear_i,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic                 fetch_valid_i,
  input  logic                 pred_taken_i,
  input  logic [PC_WIDTH-1:0]  pred_target_i,
  input  logic                 resolve_valid_i,
  input  logic                 resolve_branch_i,
  input  logic                 resolve_jump_i,
  input  logic                 resolve_taken_i,
  input  logic [PC_WIDTH-1:0]  resolve_target_i,
  input  logic [2:0]           rd_sel_i,
  output logic [CNT_WIDTH-1:0] rd_data_o,
  output logic [7:0]           ovf_o,
  output logic                 mispredict_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [PRED_LAT-1:0] vld_pn;
  logic [PRED_LAT-1:0] taken_pn;
  logic [PC_WIDTH-1:0] target_pn [PRED_LAT];

  logic [CNT_WIDTH-1:0] cnt [8];
  logic [7:0]           inc;
  logic                 pred_taken_e;
  logic                 ctrl_e;

  function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] v);
`ifdef PERF_SATURATE_EN
    return (v == CNT_MAX) ? v : v + CNT_ONE;
`else
    return v + CNT_ONE;
`endif
  endfunction

  // F -> E delay line: valid bits are control, target/direction are data
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_pn <= '0;
    end else if (flush_i) begin
      vld_pn <= '0;
    end else if (!stall_i) begin
      vld_pn[0] <= fetch_valid_i;
      for (int k = 1; k < PRED_LAT; k++) vld_pn[k] <= vld_pn[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!stall_i) begin
      taken_pn[0]  <= pred_taken_i;
      target_pn[0] <= pred_target_i;
      for (int k = 1; k < PRED_LAT; k++) begin
        taken_pn[k]  <= taken_pn[k-1];
        target_pn[k] <= target_pn[k-1];
      end
    end
  end

  // E stage: an invalid entry is treated as a not-taken prediction
  assign pred_taken_e = vld_pn[PRED_LAT-1] & taken_pn[PRED_LAT-1];
  assign ctrl_e       = resolve_valid_i & (resolve_branch_i | resolve_jump_i);
  assign mispredict_o = ctrl_e &
                        ((pred_taken_e != resolve_taken_i) |
                         (pred_taken_e & resolve_taken_i &
                          (target_pn[PRED_LAT-1] != resolve_target_i)));

  // A branch that is also flagged as a jump is accounted as a jump only
  always_comb begin
    inc    = '0;
    inc[0] = 1'b1;
    inc[1] = resolve_valid_i;
    inc[2] = resolve_valid_i & resolve_branch_i & ~resolve_jump_i;
    inc[3] = inc[2] & mispredict_o;
    inc[4] = resolve_valid_i & resolve_jump_i;
    inc[5] = inc[4] & mispredict_o;
    inc[6] = flush_i;
    inc[7] = stall_i;
  end

  always_ff @(posedge clk) begin
    if (!reset || clear_i) begin
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
      ovf_o <= '0;
    end else if (enable_i) begin
      for (int i = 0; i < 8; i++) begin
        if (inc[i]) begin
          if (cnt[i] == CNT_MAX) ovf_o[i] <= 1'b1;
          cnt[i] <= cnt_next(cnt[i]);
        end
      end
    end
  end

  // Readout samples pre-edge counter values
  always_ff @(posedge clk) begin
    if (!reset) rd_data_o <= '0;
    else        rd_data_o <= cnt[rd_sel_i];
  end

endmodule
